// File: rtl/wing_motion_ctrl.sv
// Bird motion controller: a frame-ticked flight/fall FSM that drives height, tilt and wing animation.
// Optional build macro WING_CEILING_KILL_EN: touching the ceiling while flying kills the bird.
module wing_motion_ctrl #(
    parameter logic [8:0] HOME_Y   = 9'd200,
    parameter logic [8:0] HMIN     = 9'd0,
    parameter logic [8:0] HMAX     = 9'd448,
    parameter logic [2:0] GRAVITY  = 3'd1,
    parameter logic [3:0] FLAP_VEL = 4'd7,
    parameter logic [3:0] VMAX     = 4'd9,
    parameter logic [2:0] ANIM_DIV = 3'd4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       flap_btn,
    input  logic       collide,
    input  logic       show_en,
    output logic [8:0] wing_height,
    output logic [3:0] wing_angle,
    output logic [2:0] wing_state,
    output logic       wing_valid,
    output logic       bird_dead
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FLY    = 2'd1;
    localparam logic [1:0] ST_FALL   = 2'd2;
    localparam logic [1:0] ST_GROUND = 2'd3;

    localparam logic [8:0] BOB_HI = HOME_Y + 9'd4;
    localparam logic [8:0] BOB_LO = HOME_Y - 9'd4;

    logic [1:0]        sync_r;
    logic              sync_prev_r;
    logic              flap_pending_r;
    logic [1:0]        state_r;
    logic signed [5:0] vel_r;
    logic [1:0]        bob_cnt_r;
    logic              bob_up_r;
    logic [2:0]        anim_cnt_r;
    logic [8:0]        height_r;
    logic [3:0]        angle_r;
    logic [2:0]        ws_r;
    logic              valid_r;
    logic              dead_r;

    logic              flap_edge_s;
    logic              flap_now_s;
    logic signed [5:0] vel_inc_s;
    logic signed [5:0] vel_grav_s;
    logic signed [5:0] vel_flap_s;
    logic signed [5:0] vel_step_s;
    logic signed [10:0] sum_s;
    logic              hit_top_s;
    logic              hit_gnd_s;

    logic [1:0]        state_n;
    logic signed [5:0] vel_n;
    logic [1:0]        bob_cnt_n;
    logic              bob_up_n;
    logic [2:0]        anim_cnt_n;
    logic [8:0]        height_n;
    logic [3:0]        angle_n;
    logic [2:0]        ws_n;

    // Tilt index from vertical speed: nose up when climbing, steeper as the fall speeds up.
    function automatic logic [3:0] angle_of(input logic signed [5:0] v);
        if (v <= -6'sd4) begin
            angle_of = 4'd0;
        end else if (v < 6'sd0) begin
            angle_of = 4'd1;
        end else if (v <= 6'sd1) begin
            angle_of = 4'd2;
        end else if (v >= 6'sd9) begin
            angle_of = 4'd10;
        end else begin
            angle_of = v[3:0] + 4'd1;
        end
    endfunction

    assign flap_edge_s = sync_r[1] & ~sync_prev_r;
    assign flap_now_s  = flap_pending_r | flap_edge_s;
    assign vel_inc_s   = vel_r + $signed({3'b000, GRAVITY});
    assign vel_grav_s  = (vel_inc_s > $signed({2'b00, VMAX})) ? $signed({2'b00, VMAX}) : vel_inc_s;
    assign vel_flap_s  = -$signed({2'b00, FLAP_VEL});
    assign vel_step_s  = ((state_r != ST_FALL) && flap_now_s) ? vel_flap_s : vel_grav_s;
    assign sum_s       = $signed({2'b00, height_r}) + $signed({{5{vel_step_s[5]}}, vel_step_s});
    assign hit_top_s   = (sum_s <= $signed({2'b00, HMIN}));
    assign hit_gnd_s   = (sum_s >= $signed({2'b00, HMAX}));

    // Next-state computation; only committed on frame_tick.
    always_comb begin
        state_n    = state_r;
        vel_n      = vel_r;
        bob_cnt_n  = bob_cnt_r;
        bob_up_n   = bob_up_r;
        anim_cnt_n = anim_cnt_r;
        height_n   = height_r;
        angle_n    = angle_r;
        ws_n       = ws_r;
        case (state_r)
            ST_IDLE, ST_FLY: begin
                if ((state_r == ST_FLY) || flap_now_s) begin
                    vel_n = vel_step_s;
                    if (hit_gnd_s) begin
                        height_n = HMAX;
                        state_n  = ST_GROUND;
                    end else if (hit_top_s) begin
                        height_n = HMIN;
                        vel_n    = 6'sd0;
`ifdef WING_CEILING_KILL_EN
                        state_n  = ST_FALL;
`else
                        state_n  = ST_FLY;
`endif
                    end else begin
                        height_n = sum_s[8:0];
                        state_n  = ST_FLY;
                    end
                    // Ground wins over a simultaneous collision.
                    if ((state_r == ST_FLY) && collide && !hit_gnd_s) begin
                        state_n = ST_FALL;
                        vel_n   = 6'sd0;
                    end else begin
                        state_n = state_n;
                    end
                    angle_n = angle_of(vel_n);
                end else begin
                    angle_n   = 4'd2;
                    bob_cnt_n = bob_cnt_r + 2'd1;
                    if (bob_cnt_r == 2'd3) begin
                        if (!bob_up_r) begin
                            if (height_r >= BOB_HI) begin
                                bob_up_n = 1'b1;
                                height_n = height_r - 9'd1;
                            end else begin
                                height_n = height_r + 9'd1;
                            end
                        end else if (height_r <= BOB_LO) begin
                            bob_up_n = 1'b0;
                            height_n = height_r + 9'd1;
                        end else begin
                            height_n = height_r - 9'd1;
                        end
                    end else begin
                        height_n = height_r;
                    end
                end
                if (angle_n >= 4'd3) begin
                    ws_n       = 3'd0;
                    anim_cnt_n = 3'd0;
                end else if (anim_cnt_r >= (ANIM_DIV - 3'd1)) begin
                    anim_cnt_n = 3'd0;
                    ws_n       = (ws_r >= 3'd2) ? 3'd0 : ws_r + 3'd1;
                end else begin
                    anim_cnt_n = anim_cnt_r + 3'd1;
                end
            end
            ST_FALL: begin
                vel_n   = vel_grav_s;
                angle_n = angle_of(vel_grav_s);
                if (hit_gnd_s) begin
                    height_n = HMAX;
                    state_n  = ST_GROUND;
                end else begin
                    height_n = sum_s[8:0];
                end
            end
            ST_GROUND: begin
                height_n = HMAX;
                if (flap_now_s) begin
                    state_n    = ST_IDLE;
                    height_n   = HOME_Y;
                    vel_n      = 6'sd0;
                    angle_n    = 4'd2;
                    ws_n       = 3'd0;
                    anim_cnt_n = 3'd0;
                    bob_cnt_n  = 2'd0;
                    bob_up_n   = 1'b0;
                end else begin
                    state_n = ST_GROUND;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Button synchroniser and per-frame flap latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r         <= 2'b00;
            sync_prev_r    <= 1'b0;
            flap_pending_r <= 1'b0;
        end else begin
            sync_r      <= {sync_r[0], flap_btn};
            sync_prev_r <= sync_r[1];
            if (frame_tick) begin
                flap_pending_r <= 1'b0;
            end else if (flap_edge_s) begin
                flap_pending_r <= 1'b1;
            end else begin
                flap_pending_r <= flap_pending_r;
            end
        end
    end

    // Frame-rate state and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            vel_r      <= 6'sd0;
            bob_cnt_r  <= 2'd0;
            bob_up_r   <= 1'b0;
            anim_cnt_r <= 3'd0;
            height_r   <= HOME_Y;
            angle_r    <= 4'd2;
            ws_r       <= 3'd0;
        end else if (frame_tick) begin
            state_r    <= state_n;
            vel_r      <= vel_n;
            bob_cnt_r  <= bob_cnt_n;
            bob_up_r   <= bob_up_n;
            anim_cnt_r <= anim_cnt_n;
            height_r   <= height_n;
            angle_r    <= angle_n;
            ws_r       <= ws_n;
        end
    end

    // Display enable and death flag, registered every clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            dead_r  <= 1'b0;
        end else begin
            valid_r <= show_en;
            dead_r  <= (state_r == ST_FALL) || (state_r == ST_GROUND);
        end
    end

    assign wing_height = height_r;
    assign wing_angle  = angle_r;
    assign wing_state  = ws_r;
    assign wing_valid  = valid_r;
    assign bird_dead   = dead_r;

endmodule
